// File: rtl/pim_mac_engine_pkg.sv
// Shared types and sizing for the PIM MAC engine: element/tile dimensions, FSM state type,
// job latency and a counter-width helper.
package pim_mac_engine_pkg;

    localparam int WIDTH             = 32;
    localparam int CHUNK_SIZE        = 2;
    localparam int PIM_UNIT_CAPACITY = 2;

    localparam int PIM_ENG_LATENCY = CHUNK_SIZE * CHUNK_SIZE * PIM_UNIT_CAPACITY;

    typedef enum logic {
        ENG_IDLE    = 1'b0,
        ENG_COMPUTE = 1'b1
    } pim_eng_state_t;

    // Width of a counter that runs 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pim_mac_lane.sv
// Single multiply-accumulate lane: sum = (clear ? 0 : acc) + a*b, all modulo 2**WIDTH.
module pim_mac_lane
    import pim_mac_engine_pkg::*;
#(
    parameter int LANE_WIDTH = WIDTH
) (
    input  logic [LANE_WIDTH-1:0] a,
    input  logic [LANE_WIDTH-1:0] b,
    input  logic [LANE_WIDTH-1:0] acc,
    input  logic                  clear,
    output logic [LANE_WIDTH-1:0] sum
);

    logic [LANE_WIDTH-1:0] prod;
    logic [LANE_WIDTH-1:0] base;

    // Product keeps only the low LANE_WIDTH bits; the accumulator wraps the same way.
    assign prod = a * b;
    assign base = clear ? '0 : acc;
    assign sum  = base + prod;

endmodule

// File: rtl/pim_mac_engine.sv
// PIM slot compute responder: captures one A/B sub-chunk pair and produces the CHUNK_SIZE x CHUNK_SIZE
// partial product with one time-multiplexed MAC, then pulses result_valid for one cycle.
module pim_mac_engine
    import pim_mac_engine_pkg::*;
#(
    parameter int ID                = 0,
    parameter int WIDTH             = pim_mac_engine_pkg::WIDTH,
    parameter int CHUNK_SIZE        = pim_mac_engine_pkg::CHUNK_SIZE,
    parameter int PIM_UNIT_CAPACITY = pim_mac_engine_pkg::PIM_UNIT_CAPACITY
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  valid,
    input  logic [CHUNK_SIZE-1:0][PIM_UNIT_CAPACITY-1:0][WIDTH-1:0] matrixA,
    input  logic [PIM_UNIT_CAPACITY-1:0][CHUNK_SIZE-1:0][WIDTH-1:0] matrixB,
    output logic [CHUNK_SIZE*CHUNK_SIZE-1:0][WIDTH-1:0]           result,
    output logic                                                  result_valid,
    output logic                                                  busy
);

    localparam int IW = cnt_w(CHUNK_SIZE);
    localparam int KW = cnt_w(PIM_UNIT_CAPACITY);
    localparam int RW = cnt_w(CHUNK_SIZE * CHUNK_SIZE);

    localparam logic [IW-1:0] IJ_MAX = IW'(CHUNK_SIZE - 1);
    localparam logic [KW-1:0] K_MAX  = KW'(PIM_UNIT_CAPACITY - 1);

    pim_eng_state_t state;

    logic [IW-1:0]    i_cnt;
    logic [IW-1:0]    j_cnt;
    logic [KW-1:0]    k_cnt;
    logic [WIDTH-1:0] acc;

    logic [CHUNK_SIZE-1:0][PIM_UNIT_CAPACITY-1:0][WIDTH-1:0] a_reg;
    logic [PIM_UNIT_CAPACITY-1:0][CHUNK_SIZE-1:0][WIDTH-1:0] b_reg;

    logic [WIDTH-1:0] lane_a;
    logic [WIDTH-1:0] lane_b;
    logic [WIDTH-1:0] lane_sum;
    logic             k_last;
    logic             j_last;
    logic             i_last;
    logic [RW-1:0]    res_idx;

    assign lane_a  = a_reg[i_cnt][k_cnt];
    assign lane_b  = b_reg[k_cnt][j_cnt];
    assign k_last  = (k_cnt == K_MAX);
    assign j_last  = (j_cnt == IJ_MAX);
    assign i_last  = (i_cnt == IJ_MAX);
    assign res_idx = RW'(int'(i_cnt) * CHUNK_SIZE + int'(j_cnt));
    assign busy    = (state == ENG_COMPUTE);

    pim_mac_lane #(
        .LANE_WIDTH (WIDTH)
    ) u_lane (
        .a     (lane_a),
        .b     (lane_b),
        .acc   (acc),
        .clear (k_cnt == '0),
        .sum   (lane_sum)
    );

    // NOTE: all state here is updated with non-blocking assignments so every register samples
    // the pre-edge values of the others (the lane reads acc/counters while they are being advanced).
    // NOTE: the result bank is small and the reset contract requires it to read zero, so unlike a
    // RAM it is part of the async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ENG_IDLE;
            i_cnt        <= '0;
            j_cnt        <= '0;
            k_cnt        <= '0;
            acc          <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                ENG_IDLE: begin
                    if (valid) begin
                        a_reg <= matrixA;
                        b_reg <= matrixB;
                        i_cnt <= '0;
                        j_cnt <= '0;
                        k_cnt <= '0;
                        acc   <= '0;
                        state <= ENG_COMPUTE;
                    end
                end
                ENG_COMPUTE: begin
                    // Any valid arriving here is dropped; operand regs stay untouched.
                    acc <= lane_sum;
                    if (k_last) begin
                        k_cnt           <= '0;
                        result[res_idx] <= lane_sum;
                        if (j_last) begin
                            j_cnt <= '0;
                            if (i_last) begin
                                i_cnt        <= '0;
                                state        <= ENG_IDLE;
                                result_valid <= 1'b1;
                            end else begin
                                i_cnt <= i_cnt + 1'b1;
                            end
                        end else begin
                            j_cnt <= j_cnt + 1'b1;
                        end
                    end else begin
                        k_cnt <= k_cnt + 1'b1;
                    end
                end
                default: state <= ENG_IDLE;
            endcase
        end
    end

    a_rv_not_busy: assert property (@(posedge clk) disable iff (rst) !(result_valid && busy))
        else $error("pim_mac_engine[%0d]: result_valid asserted while busy", ID);

endmodule

// File: tb/tb_pim_mac_engine.sv
// Directed self-checking bench for pim_mac_engine with the default 32-bit 2x2x2 configuration.
module tb_pim_mac_engine;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       valid;
    logic [1:0][1:0][31:0]      matrixA;
    logic [1:0][1:0][31:0]      matrixB;
    logic [3:0][31:0]           result;
    logic                       result_valid;
    logic                       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rv_pulses = 0;
    int c0;

    pim_mac_engine #(
        .ID                (0),
        .WIDTH             (32),
        .CHUNK_SIZE        (2),
        .PIM_UNIT_CAPACITY (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .valid        (valid),
        .matrixA      (matrixA),
        .matrixB      (matrixB),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (result_valid) begin
            rv_pulses++;
            check("rv_busy_excl", {63'd0, busy}, 64'd0);
        end
    end

    task automatic set_ab(input logic [31:0] a00, a01, a10, a11,
                          input logic [31:0] b00, b01, b10, b11);
        matrixA[0][0] = a00; matrixA[0][1] = a01;
        matrixA[1][0] = a10; matrixA[1][1] = a11;
        matrixB[0][0] = b00; matrixB[0][1] = b01;
        matrixB[1][0] = b10; matrixB[1][1] = b11;
    endtask

    // Drives a one-cycle valid; returns at the negedge after the accept edge with c0 set.
    task automatic pulse();
        @(negedge clk);
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        c0 = cyc;
    endtask

    task automatic wait_result(input string tag);
        int n = 0;
        while (!result_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 64'(cyc - c0), 64'd8);
    endtask

    task automatic check_res(input string tag, input logic [31:0] r0, r1, r2, r3);
        check({tag, "_r0"}, 64'(result[0]), 64'(r0));
        check({tag, "_r1"}, 64'(result[1]), 64'(r1));
        check({tag, "_r2"}, 64'(result[2]), 64'(r2));
        check({tag, "_r3"}, 64'(result[3]), 64'(r3));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int pulses0;
        rst   = 1'b1;
        valid = 1'b0;
        set_ab(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("reset_rv", {63'd0, result_valid}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check_res("reset", 0, 0, 0, 0);
        rst = 1'b0;
        idle(2);

        // Basic job plus operand capture: inputs zeroed right after the accept edge.
        set_ab(1, 2, 3, 4, 5, 6, 7, 8);
        pulse();
        set_ab(0, 0, 0, 0, 0, 0, 0, 0);
        check("basic_busy", {63'd0, busy}, 64'd1);
        wait_result("basic");
        check_res("basic", 19, 22, 43, 50);
        @(negedge clk);
        check("basic_rv_width", {63'd0, result_valid}, 64'd0);
        check("basic_idle", {63'd0, busy}, 64'd0);
        idle(2);

        // Valid while busy is dropped.
        pulses0 = rv_pulses;
        set_ab(2, 0, 0, 2, 1, 2, 3, 4);
        pulse();
        set_ab(1, 1, 1, 1, 1, 1, 1, 1);
        idle(2);
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        wait_result("busy_drop");
        check_res("busy_drop", 2, 4, 6, 8);
        idle(12);
        check("busy_drop_pulses", 64'(rv_pulses - pulses0), 64'd1);
        check("busy_drop_idle", {63'd0, busy}, 64'd0);

        // Back-to-back: next valid presented during the result_valid cycle.
        set_ab(1, 2, 3, 4, 5, 6, 7, 8);
        pulse();
        wait_result("b2b_first");
        check_res("b2b_first", 19, 22, 43, 50);
        set_ab(1, 0, 0, 1, 9, 8, 7, 6);
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        c0 = cyc;
        check("b2b_accepted", {63'd0, busy}, 64'd1);
        check("b2b_rv_drop", {63'd0, result_valid}, 64'd0);
        wait_result("b2b_second");
        check_res("b2b_second", 9, 8, 7, 6);
        idle(2);

        // Modulo-2**32 wrap of products and accumulator.
        set_ab(32'hFFFF_FFFF, 1, 0, 0, 2, 1, 3, 0);
        pulse();
        wait_result("wrap");
        check_res("wrap", 32'h0000_0001, 32'hFFFF_FFFF, 0, 0);
        idle(2);

        // Reset four cycles into a job aborts it.
        pulses0 = rv_pulses;
        set_ab(1, 1, 1, 1, 5, 6, 7, 8);
        pulse();
        idle(3);
        rst = 1'b1;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_rv", {63'd0, result_valid}, 64'd0);
        check_res("abort", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        idle(12);
        check("abort_no_rv", 64'(rv_pulses - pulses0), 64'd0);
        pulse();
        wait_result("after_abort");
        check_res("after_abort", 12, 14, 12, 14);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
